// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, format enum and decoded-instruction struct for the decode stage
package decode_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    // RV64-only opcodes
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    // The immediate is always carried at the widest XLEN; a narrower stage
    // takes the low bits, which is still a correct sign extension.
    localparam int IMM_W = 64;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [6:0]       funct7;
        fmt_e             fmt;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } decoded_t;

    localparam decoded_t DECODED_RST = '{
        opcode:  7'd0,
        rd:      5'd0,
        funct3:  3'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        funct7:  7'd0,
        fmt:     FMT_NONE,
        imm:     '0,
        illegal: 1'b0
    };

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational RV32I/RV64I field split, format select and immediate extraction
//
// Ports:
//   instr_i  raw 32-bit instruction
//   dec_o    decoded fields, format, sign-extended immediate (IMM_W bits), illegal flag
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [IMM_W-1:0] imm_i;
    logic [IMM_W-1:0] imm_s;
    logic [IMM_W-1:0] imm_b;
    logic [IMM_W-1:0] imm_u;
    logic [IMM_W-1:0] imm_j;

    // instr[31] is the sign bit of every format; it fills all bits above the
    // highest encoded immediate bit.
    assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
    assign imm_j = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec_o         = DECODED_RST;
        dec_o.opcode  = instr_i[6:0];
        dec_o.rd      = instr_i[11:7];
        dec_o.funct3  = instr_i[14:12];
        dec_o.rs1     = instr_i[19:15];
        dec_o.rs2     = instr_i[24:20];
        dec_o.funct7  = instr_i[31:25];
        dec_o.fmt     = FMT_NONE;
        dec_o.imm     = '0;
        dec_o.illegal = 1'b1;

        // Compressed / reserved quadrants are not supported.
        if (instr_i[1:0] == 2'b11) begin
            unique case (instr_i[6:0])
                OPC_LUI, OPC_AUIPC: begin
                    dec_o.fmt     = FMT_U;
                    dec_o.imm     = imm_u;
                    dec_o.illegal = 1'b0;
                end
                OPC_JAL: begin
                    dec_o.fmt     = FMT_J;
                    dec_o.imm     = imm_j;
                    dec_o.illegal = 1'b0;
                end
                OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISCMEM, OPC_SYSTEM: begin
                    dec_o.fmt     = FMT_I;
                    dec_o.imm     = imm_i;
                    dec_o.illegal = 1'b0;
                end
                OPC_STORE: begin
                    dec_o.fmt     = FMT_S;
                    dec_o.imm     = imm_s;
                    dec_o.illegal = 1'b0;
                end
                OPC_BRANCH: begin
                    dec_o.fmt     = FMT_B;
                    dec_o.imm     = imm_b;
                    dec_o.illegal = 1'b0;
                end
                OPC_OP: begin
                    dec_o.fmt     = FMT_R;
                    dec_o.illegal = 1'b0;
                end
                OPC_OPIMM32: begin
                    if (XLEN == 64) begin
                        dec_o.fmt     = FMT_I;
                        dec_o.imm     = imm_i;
                        dec_o.illegal = 1'b0;
                    end
                end
                OPC_OP32: begin
                    if (XLEN == 64) begin
                        dec_o.fmt     = FMT_R;
                        dec_o.illegal = 1'b0;
                    end
                end
                default: begin
                    dec_o.fmt     = FMT_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered handshaked decode stage with two-entry skid buffer and flush
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop everything buffered; in-transfer this cycle is discarded
//   in_valid/in_ready   fetch-side handshake; in_instr, in_pc carried with it
//   out_valid/out_ready downstream handshake
//   out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7,
//   out_fmt, out_imm, out_illegal   registered decode results
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    decoded_t        dec;
    decoded_t        out_q, out_d;
    decoded_t        skid_q, skid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_xfer;
    logic            out_xfer;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

    assign in_ready = !skid_valid_q;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid only fills behind a valid output, so out_valid_q is 1 here
            // and in_ready is 0: the only event is the output draining.
            if (out_ready) begin
                out_d        = skid_q;
                out_pc_d     = skid_pc_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!out_valid_q || out_ready) begin
                out_d       = dec;
                out_pc_d    = in_pc;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_pc_d    = in_pc;
                skid_valid_d = 1'b1;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= DECODED_RST;
            out_pc_q     <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= DECODED_RST;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_opcode  = out_q.opcode;
    assign out_rd      = out_q.rd;
    assign out_funct3  = out_q.funct3;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_funct7  = out_q.funct7;
    assign out_fmt     = out_q.fmt;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_illegal = out_q.illegal;

    // Above XLEN the stored immediate bits are pure sign copies and unused.
    if (XLEN < IMM_W) begin : g_imm_trunc
        logic unused_imm_hi;
        assign unused_imm_hi = ^out_q.imm[IMM_W-1:XLEN];
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (XLEN=32 main instance, XLEN=64 side instance)
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_fmt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_pc64, out_imm64;
    logic [6:0]  out_opcode64, out_funct764;
    logic [4:0]  out_rd64, out_rs164, out_rs264;
    logic [2:0]  out_funct364, out_fmt64;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc({32'd0, in_pc}),
        .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
        .out_opcode(out_opcode64), .out_rd(out_rd64), .out_funct3(out_funct364),
        .out_rs1(out_rs164), .out_rs2(out_rs264), .out_funct7(out_funct764),
        .out_fmt(out_fmt64), .out_imm(out_imm64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    logic [31:0] pc_ctr = 32'h0000_1000;

    // Reference decode written from the ISA formats using signed shifts/extension.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit rv64);
        exp_t e;
        logic signed [63:0] s;
        bit ok;
        e.instr = ins; e.pc = pc; e.fmt = 3'd6; e.imm = 64'd0; e.ill = 1'b1;
        s = 64'sd0; ok = 1'b0;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'h37, 7'h17: begin e.fmt = 3'd4; s = $signed({ins[31:12], 12'h000}); ok = 1'b1; end
                7'h6F: begin e.fmt = 3'd5; s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); ok = 1'b1; end
                7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin e.fmt = 3'd1; s = $signed(ins) >>> 20; ok = 1'b1; end
                7'h23: begin e.fmt = 3'd2; s = $signed({ins[31:25], ins[11:7]}); ok = 1'b1; end
                7'h63: begin e.fmt = 3'd3; s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); ok = 1'b1; end
                7'h33: begin e.fmt = 3'd0; ok = 1'b1; end
                7'h1B: if (rv64) begin e.fmt = 3'd1; s = $signed(ins) >>> 20; ok = 1'b1; end
                7'h3B: if (rv64) begin e.fmt = 3'd0; ok = 1'b1; end
                default: ok = 1'b0;
            endcase
        end
        if (ok) begin
            e.imm = s;
            e.ill = 1'b0;
        end else begin
            e.fmt = 3'd6;
        end
        return e;
    endfunction

    // Scoreboard: decide transfers at the negedge, update the queue at the edge.
    bit   pop_p = 1'b0;
    bit   acc_p = 1'b0;
    exp_t acc_e;

    always @(negedge clk) begin
        exp_t e;
        pop_p = 1'b0;
        acc_p = 1'b0;
        if (!rst && !flush) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got pc=%h instr-op=%h, required no output", out_pc, out_opcode);
                end else begin
                    e = sb_q[0];
                    if ({out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7, out_fmt, out_imm, out_illegal} !==
                        {e.pc, e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[31:25], e.fmt, e.imm[31:0], e.ill}) begin
                        n_bad++;
                        $display("FAIL sb_out: got pc=%h op=%h fmt=%0d imm=%h ill=%b, required pc=%h instr=%h fmt=%0d imm=%h ill=%b",
                                 out_pc, out_opcode, out_fmt, out_imm, out_illegal, e.pc, e.instr, e.fmt, e.imm[31:0], e.ill);
                    end
                    pop_p = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                acc_p = 1'b1;
                acc_e = model(in_instr, in_pc, 1'b0);
            end
        end
    end

    always @(posedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (pop_p && sb_q.size() > 0) void'(sb_q.pop_front());
            if (acc_p) sb_q.push_back(acc_e);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        bit acc;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: instr=%h not accepted within 50 cycles, required acceptance", ins);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_cmp++;
        if ({out_valid, out_fmt, out_imm, out_pc} !== {1'b0, 3'd6, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b fmt=%0d imm=%h pc=%h required 0/6/0/0", out_valid, out_fmt, out_imm, out_pc);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  rd;
        logic [2:0]  fmt64;
        logic [63:0] imm64;
    } vec_t;

    task automatic test_decode_vectors();
        vec_t v[9];
        v[0] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 5'd1,  3'd1, 64'hFFFFFFFF_FFFFFFFF};
        v[1] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 5'd29, 3'd3, 64'hFFFFFFFF_FFFFFFFC};
        v[2] = '{32'h123452B7, 3'd4, 32'h12345000, 1'b0, 5'd5,  3'd4, 64'h00000000_12345000};
        v[3] = '{32'h00000000, 3'd6, 32'h00000000, 1'b1, 5'd0,  3'd6, 64'h0};
        v[4] = '{32'hFFF0009B, 3'd6, 32'h00000000, 1'b1, 5'd1,  3'd1, 64'hFFFFFFFF_FFFFFFFF};
        v[5] = '{32'h00112623, 3'd2, 32'h0000000C, 1'b0, 5'd12, 3'd2, 64'h0000000C};
        v[6] = '{32'hFF9FF06F, 3'd5, 32'hFFFFFFF8, 1'b0, 5'd0,  3'd5, 64'hFFFFFFFF_FFFFFFF8};
        v[7] = '{32'h002081B3, 3'd0, 32'h00000000, 1'b0, 5'd3,  3'd0, 64'h0};
        v[8] = '{32'hFFF00001, 3'd6, 32'h00000000, 1'b1, 5'd0,  3'd6, 64'h0};
        out_ready = 1'b1;
        foreach (v[k]) begin
            send(v[k].instr);
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_fmt, out_imm, out_illegal, out_rd} !== {1'b1, v[k].fmt, v[k].imm, v[k].ill, v[k].rd}) begin
                n_bad++;
                $display("FAIL vec32_%0d: got v=%b fmt=%0d imm=%h ill=%b rd=%0d required 1/%0d/%h/%b/%0d",
                         k, out_valid, out_fmt, out_imm, out_illegal, out_rd, v[k].fmt, v[k].imm, v[k].ill, v[k].rd);
            end
            n_cmp++;
            if ({out_valid64, out_fmt64, out_imm64} !== {1'b1, v[k].fmt64, v[k].imm64}) begin
                n_bad++;
                $display("FAIL vec64_%0d: got v=%b fmt=%0d imm=%h required 1/%0d/%h",
                         k, out_valid64, out_fmt64, out_imm64, v[k].fmt64, v[k].imm64);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] pc_a;
        logic [31:0] imm_snap;
        bit acc;
        out_ready = 1'b0;
        pc_a = pc_ctr;
        in_valid = 1'b1;
        in_instr = 32'h00500113; in_pc = pc_ctr; pc_ctr += 4; step();   // A
        in_instr = 32'hFE000EE3; in_pc = pc_ctr; pc_ctr += 4; step();   // B -> skid
        in_instr = 32'h123452B7; in_pc = pc_ctr; pc_ctr += 4;           // C held
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, pc_a}) begin
            n_bad++;
            $display("FAIL bp_stall: got in_ready=%b out_valid=%b pc=%h required 0/1/%h", in_ready, out_valid, out_pc, pc_a);
        end
        imm_snap = out_imm;
        step(); step();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_pc, out_imm} !== {1'b0, pc_a, imm_snap}) begin
            n_bad++;
            $display("FAIL bp_hold: got in_ready=%b pc=%h imm=%h required 0/%h/%h", in_ready, out_pc, out_imm, pc_a, imm_snap);
        end
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!acc) begin n_bad++; $display("FAIL bp_c_accept: got not accepted required accepted"); end
        repeat (4) step();
        n_cmp++;
        if (sb_q.size() != 0) begin n_bad++; $display("FAIL bp_drain: got %0d pending required 0", sb_q.size()); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 32'hDEAD0000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL flush_state: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_leak: got out_valid=%b pc=%h required 0", out_valid, out_pc); end
    endtask

    task automatic test_random();
        logic [6:0] ops[14];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33, 7'h1B, 7'h3B, 7'h7F};
        for (int i = 0; i < 40; i++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) r[1:0] = 2'($urandom_range(0, 2));
            out_ready = in_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            send(r);
        end
        out_ready = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (sb_q.size() != 0) begin n_bad++; $display("FAIL rand_drain: got %0d pending required 0", sb_q.size()); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        send(32'hFFF00093);
        send(32'hFE000EE3);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL rstfull_pre: got out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rstfull_hs: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        n_cmp++;
        if ({out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7, out_fmt, out_imm, out_illegal} !==
            {32'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 3'd6, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL rstfull_data: got pc=%h op=%h rd=%0d fmt=%0d imm=%h ill=%b required zeros with fmt=6",
                     out_pc, out_opcode, out_rd, out_fmt, out_imm, out_illegal);
        end
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode_vectors();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked RV32I/RV64I decode stage between fetch and register-read/execute.
- Splits the instruction into fields.
- Selects and sign-extends the one immediate that matches the opcode's format to XLEN.
- Flags illegal encodings.
- Carries the PC alongside the decoded fields.
- A two-entry skid buffer gives full throughput under valid/ready backpressure, plus a flush input for branch redirects.

Parameters:
XLEN, 32, datapath width: 32 or 64. Sets immediate and PC width and enables the RV64 opcodes.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  drop all buffered instructions this cycle
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded instruction available
out_ready  in  1  downstream accepts
out_pc  out  XLEN  PC of the decoded instruction
out_opcode  out  7  instr[6:0]
out_rd  out  5  instr[11:7]
out_funct3  out  3  instr[14:12]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_funct7  out  7  instr[31:25]
out_fmt  out  3  format code: R/I/S/B/U/J/NONE
out_imm  out  XLEN  selected immediate, sign-extended to XLEN
out_illegal  out  1  unsupported or illegal encoding

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: out_valid=0, skid_valid=0, all out_* data=0, out_fmt=NONE.
- in_ready = !skid_valid. It is purely a function of registered state, so it is 1 during and after reset.
- Decode is combinational on in_instr and is captured into the output register. Latency is 1 cycle: an accepted instruction at edge N appears on out_* after edge N.
- Transfer rules: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- Output register empty, or draining this cycle: the input is loaded directly into the output register.
- Output register full and stalled (out_valid & !out_ready) with an in-transfer: the input goes to the skid register, and skid_valid=1.
- Output register drains while skid_valid=1: the skid register moves to the output register, and skid_valid=0. A new input cannot arrive in the same cycle because in_ready=0.
- Stalled outputs hold every out_* value stable until out-transfer.
- flush: out_valid=0 and skid_valid=0 next cycle. Any in-transfer in the flush cycle is discarded. flush has priority over all loads. rst has priority over flush.
- Format and immediate selection by opcode:
  - 0110111 LUI, 0010111 AUIPC -> U. imm = sext({instr[31:12],12'b0}).
  - 1101111 JAL -> J. imm = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM -> I. imm = sext(instr[31:20]).
  - 0100011 STORE -> S. imm = sext({instr[31:25],instr[11:7]}).
  - 1100011 BRANCH -> B. imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 0110011 OP -> R. imm = 0.
  - XLEN=64 only: 0011011 OP-IMM-32 -> I; 0111011 OP-32 -> R.
- sext is taken from instr[31] up to XLEN bits. The U-type upper bits also come from instr[31].
- illegal=1, fmt=NONE, imm=0 when:
  - instr[1:0] != 2'b11, or
  - the opcode is not listed above, or
  - an RV64 opcode is used with XLEN=32.
- An illegal instruction still transfers normally. Field outputs still carry the raw bit slices.

Decomposition:
- Package decode_pkg holds:
  - the opcode localparams (OPC_LUI ... OPC_OP32);
  - the fmt_e enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE);
  - a decoded_t struct covering every out_* field except the handshake.
- Sub-module decode_comb (purely combinational, parameter XLEN) maps instr to decoded_t.
- decode_stage instantiates decode_comb once, on in_instr, and holds the output and skid registers of decoded_t plus pc.

Test Plan:
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_fmt=I, out_rd=1, out_rs1=0, out_imm=0xFFFFFFFF, out_illegal=0.
- in_instr=0xFE000EE3 (beq x0,x0,-4) -> out_fmt=B, out_imm=0xFFFFFFFC. in_instr=0x123452B7 (lui x5,0x12345) -> out_fmt=U, out_rd=5, out_imm=0x12345000.
- Backpressure with out_ready=0 and three back-to-back inputs A, B, C -> A is held on the outputs, B goes to skid, in_ready=0 and C is not accepted. Raising out_ready emits A then B then C in order, with no loss or duplication.
- Skid full, then flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flushed-cycle input never appears on the outputs.
- in_instr=0x00000000 -> out_illegal=1, out_fmt=NONE, out_imm=0. XLEN=32 with 0xFFF0009B (addiw) -> illegal. XLEN=64 with the same encoding -> fmt=I, imm=0xFFFFFFFFFFFFFFFF.
- rst asserted while out_valid=1 and skid_valid=1 -> after the edge out_valid=0, in_ready=1, and all data outputs are 0.
